// File: rtl/mpc_host_pkg.sv
// Shared types and solver address map for the MPC host bus master.
// Op/status encodings match the command and response port fields.
package mpc_host_pkg;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_READ    = 2'b01,
    OP_POLL    = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_TIMEOUT = 2'b01,
    ST_ILLEGAL = 2'b10
  } status_e;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD_WAIT,
    RSP
  } state_e;

  // Solver control block registers
  localparam logic [15:0] ADDR_CTRL       = 16'h0000;
  localparam logic [15:0] ADDR_START_DONE = 16'h0000;
  localparam logic [15:0] ADDR_ITER       = 16'h0004;
  localparam logic [15:0] ADDR_HORIZON    = 16'h0008;
  localparam logic [15:0] ADDR_CONVERGED  = 16'h000C;

  // Data regions sit on 4 KiB boundaries from 0x1000 up to 0x9000
  localparam int          NUM_REGIONS     = 9;
  localparam logic [15:0] REGION_STRIDE   = 16'h1000;

  function automatic logic [15:0] region_base(input int unsigned idx);
    return REGION_STRIDE * 16'(idx + 1);
  endfunction

endpackage

// File: rtl/mpc_host_master_if.sv
// Command, response and solver-bus signals of the MPC host master.
// The master modport is the bridge itself; slave is the host/solver side.
interface mpc_host_master_if
  import mpc_host_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_data;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  status_e               rsp_status;

  logic [ADDR_WIDTH-1:0] avm_address;
  logic                  avm_chipselect;
  logic                  avm_read;
  logic                  avm_write;
  logic [DATA_WIDTH-1:0] avm_writedata;
  logic [DATA_WIDTH-1:0] avm_readdata;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, avm_readdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_status,
           avm_address, avm_chipselect, avm_read, avm_write, avm_writedata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, avm_readdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_status,
           avm_address, avm_chipselect, avm_read, avm_write, avm_writedata
  );

endinterface

// File: rtl/mpc_host_master.sv
// Host command bridge onto the solver bus: single write, single read, and
// polled read that repeats until (data & mask) != 0 or the strobe budget runs out.
module mpc_host_master
  import mpc_host_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int POLL_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  mpc_host_master_if.master  bus,
  output logic               busy
);

  localparam int PCNT_W = $clog2(POLL_TIMEOUT + 1);
  localparam int WCNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [PCNT_W-1:0] POLL_MAX  = PCNT_W'(POLL_TIMEOUT);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(READ_LATENCY - 1);

  state_e                state_reg, state_next;
  op_e                   op_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [PCNT_W-1:0]     poll_cnt_reg;
  logic [WCNT_W-1:0]     wait_cnt_reg;

  logic [ADDR_WIDTH-1:0] avm_address_reg;
  logic [DATA_WIDTH-1:0] avm_writedata_reg;
  logic                  avm_chipselect_reg, avm_read_reg, avm_write_reg;
  logic [DATA_WIDTH-1:0] rsp_data_reg;
  status_e               rsp_status_reg;

  logic accept, wait_done, poll_miss;

  assign accept    = (state_reg == IDLE) && bus.cmd_valid;
  assign wait_done = (state_reg == RD_WAIT) && (wait_cnt_reg == WAIT_LAST);
  assign poll_miss = (op_reg == OP_POLL) && ((bus.avm_readdata & data_reg) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.cmd_valid) begin
          case (op_e'(bus.cmd_op))
            OP_WRITE:         state_next = WR;
            OP_READ, OP_POLL: state_next = RD;
            default:          state_next = RSP;
          endcase
        end
      end
      WR:      state_next = RSP;
      RD:      state_next = RD_WAIT;
      RD_WAIT: begin
        if (wait_done) begin
          if (poll_miss && (poll_cnt_reg != POLL_MAX)) state_next = RD;
          else                                         state_next = RSP;
        end
      end
      RSP:     if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are computed from the next state so they are registered yet
  // line up exactly with the WR/RD cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg             <= OP_WRITE;
      addr_reg           <= '0;
      data_reg           <= '0;
      poll_cnt_reg       <= '0;
      wait_cnt_reg       <= '0;
      avm_address_reg    <= '0;
      avm_writedata_reg  <= '0;
      avm_chipselect_reg <= 1'b0;
      avm_read_reg       <= 1'b0;
      avm_write_reg      <= 1'b0;
      rsp_data_reg       <= '0;
      rsp_status_reg     <= ST_OK;
    end else begin
      avm_chipselect_reg <= (state_next == WR) || (state_next == RD);
      avm_read_reg       <= (state_next == RD);
      avm_write_reg      <= (state_next == WR);

      if (state_next == WR || state_next == RD)
        avm_address_reg <= accept ? bus.cmd_addr : addr_reg;
      if (state_next == WR)
        avm_writedata_reg <= accept ? bus.cmd_data : data_reg;

      if (accept) begin
        op_reg       <= op_e'(bus.cmd_op);
        addr_reg     <= bus.cmd_addr;
        data_reg     <= bus.cmd_data;
        poll_cnt_reg <= '0;
        if (op_e'(bus.cmd_op) == OP_ILLEGAL) begin
          rsp_data_reg   <= '0;
          rsp_status_reg <= ST_ILLEGAL;
        end
      end

      if (state_reg == RD) poll_cnt_reg <= poll_cnt_reg + 1'b1;

      if (state_reg == RD_WAIT && !wait_done) wait_cnt_reg <= wait_cnt_reg + 1'b1;
      else                                    wait_cnt_reg <= '0;

      if (state_reg == WR) begin
        rsp_data_reg   <= '0;
        rsp_status_reg <= ST_OK;
      end

      // A hit or a plain read reports OK; only an exhausted poll reports timeout
      if (wait_done) begin
        rsp_data_reg   <= bus.avm_readdata;
        rsp_status_reg <= poll_miss ? ST_TIMEOUT : ST_OK;
      end
    end
  end

  assign bus.cmd_ready      = (state_reg == IDLE);
  assign bus.rsp_valid      = (state_reg == RSP);
  assign bus.rsp_data       = rsp_data_reg;
  assign bus.rsp_status     = rsp_status_reg;
  assign bus.avm_address    = avm_address_reg;
  assign bus.avm_chipselect = avm_chipselect_reg;
  assign bus.avm_read       = avm_read_reg;
  assign bus.avm_write      = avm_write_reg;
  assign bus.avm_writedata  = avm_writedata_reg;
  assign busy               = (state_reg != IDLE);

endmodule
